// File: rtl/vga_sync_decoder.sv
// VGA sync decoder: synchronises external hsync/vsync, measures line and
// frame timing, and tracks whether the incoming timing is stable (locked).
module vga_sync_decoder #(
    parameter int LOCK_FRAMES = 2,
    parameter int H_MAX       = 4095,
    parameter int V_MAX       = 2047
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        hsync_n,
    input  logic        vsync_n,
    output logic [11:0] x,
    output logic [10:0] y,
    output logic [11:0] line_len,
    output logic [10:0] frame_lines,
    output logic        line_start,
    output logic        frame_start,
    output logic        locked,
    output logic        err
);

    localparam logic [11:0] H_LIM    = 12'(H_MAX);
    localparam logic [10:0] V_LIM    = 11'(V_MAX);
    localparam logic [3:0]  LOCK_CNT = 4'(LOCK_FRAMES);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        TRACK  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    // [0],[1] form the synchroniser, [2] holds the previous synchronised value
    logic [2:0]  hs_pipe_r, vs_pipe_r;
    logic        hs_fall_r, vs_fall_r;
    logic [11:0] x_r, line_len_r;
    logic [10:0] y_r, frame_lines_r;
    logic        line_seen_r;
    logic [11:0] x_inc_s, cur_line_s;
    logic [10:0] y_inc_s;

    state_t      state_r, state_s;
    logic        ref_valid_r, ref_valid_s;
    logic [11:0] ref_line_r, ref_line_s;
    logic [10:0] ref_frame_r, ref_frame_s;
    logic [3:0]  match_cnt_r, match_cnt_s, match_inc_s;
    logic        locked_r, err_r, err_s;
    logic        line_ok_s, frame_ok_s, lost_s;

    // Two line lengths are treated as equal when they differ by at most one clock
    function automatic logic len_close(input logic [11:0] a, input logic [11:0] b);
        logic [11:0] d;
        d = (a >= b) ? (a - b) : (b - a);
        return (d <= 12'd1);
    endfunction

    // Synchronise the sync pins and register their falling edges
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hs_pipe_r <= 3'b111;
            vs_pipe_r <= 3'b111;
            hs_fall_r <= 1'b0;
            vs_fall_r <= 1'b0;
        end else begin
            hs_pipe_r <= {hs_pipe_r[1:0], hsync_n};
            vs_pipe_r <= {vs_pipe_r[1:0], vsync_n};
            hs_fall_r <= hs_pipe_r[2] & ~hs_pipe_r[1];
            vs_fall_r <= vs_pipe_r[2] & ~vs_pipe_r[1];
        end
    end

    // Saturating increments and the length of the line just finished
    always_comb begin
        x_inc_s    = (x_r >= H_LIM) ? H_LIM : (x_r + 12'd1);
        y_inc_s    = (y_r >= V_LIM) ? V_LIM : (y_r + 11'd1);
        cur_line_s = hs_fall_r ? x_inc_s : line_len_r;
    end

    // Position counters and period measurements; vsync wins over hsync for y
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_r           <= 12'd0;
            y_r           <= 11'd0;
            line_len_r    <= 12'd0;
            frame_lines_r <= 11'd0;
            line_seen_r   <= 1'b0;
        end else begin
            if (hs_fall_r) begin
                x_r         <= 12'd0;
                line_len_r  <= x_inc_s;
                line_seen_r <= 1'b1;
            end else begin
                x_r <= x_inc_s;
            end
            if (vs_fall_r) begin
                y_r           <= 11'd0;
                frame_lines_r <= y_inc_s;
            end else if (hs_fall_r) begin
                y_r <= y_inc_s;
            end else begin
                y_r <= y_r;
            end
        end
    end

    // Lock tracking: next state, reference capture and loss detection
    always_comb begin
        state_s     = state_r;
        ref_valid_s = ref_valid_r;
        ref_line_s  = ref_line_r;
        ref_frame_s = ref_frame_r;
        match_cnt_s = match_cnt_r;
        err_s       = 1'b0;
        match_inc_s = match_cnt_r + 4'd1;
        line_ok_s   = len_close(cur_line_s, ref_line_r);
        frame_ok_s  = (y_inc_s == ref_frame_r);
        lost_s      = (hs_fall_r && !line_ok_s) || (vs_fall_r && !frame_ok_s) || (x_r >= H_LIM);
        case (state_r)
            SEARCH: begin
                if (vs_fall_r) begin
                    state_s     = TRACK;
                    ref_valid_s = 1'b0;
                    match_cnt_s = 4'd0;
                end else begin
                    state_s = SEARCH;
                end
            end
            TRACK: begin
                if (vs_fall_r) begin
                    if (ref_valid_r && line_seen_r && line_ok_s && frame_ok_s) begin
                        match_cnt_s = match_inc_s;
                        if (match_inc_s >= LOCK_CNT) begin
                            state_s = LOCKED;
                        end else begin
                            state_s = TRACK;
                        end
                    end else begin
                        // A line measured before any hsync was seen is not a real line
                        ref_line_s  = cur_line_s;
                        ref_frame_s = y_inc_s;
                        ref_valid_s = line_seen_r;
                        match_cnt_s = 4'd0;
                    end
                end else begin
                    state_s = TRACK;
                end
            end
            LOCKED: begin
                if (lost_s) begin
                    state_s     = SEARCH;
                    err_s       = 1'b1;
                    match_cnt_s = 4'd0;
                    ref_valid_s = 1'b0;
                end else begin
                    state_s = LOCKED;
                end
            end
            default: begin
                state_s     = SEARCH;
                match_cnt_s = 4'd0;
                ref_valid_s = 1'b0;
            end
        endcase
    end

    // Lock state register with registered locked/err outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= SEARCH;
            ref_valid_r <= 1'b0;
            ref_line_r  <= 12'd0;
            ref_frame_r <= 11'd0;
            match_cnt_r <= 4'd0;
            locked_r    <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            state_r     <= state_s;
            ref_valid_r <= ref_valid_s;
            ref_line_r  <= ref_line_s;
            ref_frame_r <= ref_frame_s;
            match_cnt_r <= match_cnt_s;
            locked_r    <= (state_s == LOCKED);
            err_r       <= err_s;
        end
    end

    assign x           = x_r;
    assign y           = y_r;
    assign line_len    = line_len_r;
    assign frame_lines = frame_lines_r;
    assign line_start  = hs_fall_r;
    assign frame_start = vs_fall_r;
    assign locked      = locked_r;
    assign err         = err_r;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Testbench for vga_sync_decoder: scenario table, hand-written corner
// sequences and randomised frames, all checked every cycle against an
// event-level timing model.
module tb_vga_sync_decoder;

    localparam int LOCKF = 2;
    localparam int HM    = 4095;
    localparam int VM    = 2047;
    localparam int HW    = 4;

    logic        clk = 1'b0;
    logic        rst_n, hsync_n, vsync_n;
    logic [11:0] x, line_len;
    logic [10:0] y, frame_lines;
    logic        line_start, frame_start, locked, err;

    always #5 clk = ~clk;

    vga_sync_decoder #(.LOCK_FRAMES(LOCKF), .H_MAX(HM), .V_MAX(VM)) dut (
        .clk(clk), .rst_n(rst_n), .hsync_n(hsync_n), .vsync_n(vsync_n),
        .x(x), .y(y), .line_len(line_len), .frame_lines(frame_lines),
        .line_start(line_start), .frame_start(frame_start),
        .locked(locked), .err(err)
    );

    int checks = 0;
    int errors = 0;
    int err_pulses = 0;

    // ---------------- reference model (event timestamps) ----------------
    int m_e;                 // clock edges since reset release
    bit m_last_h, m_last_v;  // pin value at previous edge
    int q_h[$], q_v[$];      // edges at which a detected assertion is announced
    bit m_hs_prev, m_vs_prev;
    int m_t_hs;              // edge of the latest announced hsync
    int m_hs_total;          // hsync announcements already accounted for
    int m_lines;             // hsyncs since latest vsync
    int m_x, m_y, m_line_len, m_frame;
    bit m_ls, m_fs, m_locked, m_err;
    int m_mode;              // 0 searching, 1 tracking, 2 locked
    bit m_have_ref;
    int m_ref_len, m_ref_frame, m_matches;

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic int iabs(input int a);
        return (a < 0) ? -a : a;
    endfunction

    task automatic model_reset();
        m_e = 0; m_last_h = 1'b1; m_last_v = 1'b1;
        q_h.delete(); q_v.delete();
        m_hs_prev = 1'b0; m_vs_prev = 1'b0;
        m_t_hs = -1; m_hs_total = 0; m_lines = 0;
        m_x = 0; m_y = 0; m_line_len = 0; m_frame = 0;
        m_ls = 1'b0; m_fs = 1'b0; m_locked = 1'b0; m_err = 1'b0;
        m_mode = 0; m_have_ref = 1'b0; m_ref_len = 0; m_ref_frame = 0; m_matches = 0;
    endtask

    task automatic model_step(input bit h, input bit v);
        int x_before;
        bit seen_before, hs_now, vs_now;
        m_e++;
        // a pin sampled low after high is announced two edges later
        if (m_last_h && !h) q_h.push_back(m_e + 2);
        if (m_last_v && !v) q_v.push_back(m_e + 2);
        m_last_h = h;
        m_last_v = v;
        hs_now = 1'b0;
        vs_now = 1'b0;
        if (q_h.size() > 0 && q_h[0] == m_e) begin hs_now = 1'b1; void'(q_h.pop_front()); end
        if (q_v.size() > 0 && q_v[0] == m_e) begin vs_now = 1'b1; void'(q_v.pop_front()); end
        // announcements from the previous edge take effect now
        x_before    = m_x;
        seen_before = (m_hs_total > 0);
        if (m_hs_prev) begin
            m_line_len = imin((m_e - 1) - m_t_hs, HM);
            m_t_hs     = m_e - 1;
            m_hs_total++;
        end
        m_x = imin(m_e - (m_t_hs + 1), HM);
        if (m_vs_prev) begin
            m_frame = imin(m_lines + 1, VM);
            m_lines = 0;
        end else if (m_hs_prev) begin
            m_lines++;
        end
        m_y   = imin(m_lines, VM);
        m_err = 1'b0;
        if (m_mode == 2) begin
            if ((m_hs_prev && iabs(m_line_len - m_ref_len) > 1) ||
                (m_vs_prev && m_frame != m_ref_frame) || x_before == HM) begin
                m_mode = 0;
                m_err  = 1'b1;
            end
        end else if (m_mode == 1) begin
            if (m_vs_prev) begin
                if (m_have_ref && seen_before && iabs(m_line_len - m_ref_len) <= 1 &&
                    m_frame == m_ref_frame) begin
                    m_matches++;
                    if (m_matches >= LOCKF) m_mode = 2;
                end else begin
                    m_ref_len   = m_line_len;
                    m_ref_frame = m_frame;
                    m_have_ref  = seen_before;
                    m_matches   = 0;
                end
            end
        end else begin
            if (m_vs_prev) begin
                m_mode     = 1;
                m_have_ref = 1'b0;
                m_matches  = 0;
            end
        end
        m_locked  = (m_mode == 2);
        m_ls      = hs_now;
        m_fs      = vs_now;
        m_hs_prev = hs_now;
        m_vs_prev = vs_now;
    endtask

    // ---------------- checking helpers ----------------
    task automatic check_val(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_cycle();
        checks++;
        if ({x, y, line_len, frame_lines, line_start, frame_start, locked, err} !==
            {12'(m_x), 11'(m_y), 12'(m_line_len), 11'(m_frame), m_ls, m_fs, m_locked, m_err}) begin
            errors++;
            $display("FAIL cycle t=%0t (got/expected): x=%0d/%0d y=%0d/%0d len=%0d/%0d fl=%0d/%0d ls=%b/%b fs=%b/%b lk=%b/%b err=%b/%b",
                     $time, x, m_x, y, m_y, line_len, m_line_len, frame_lines, m_frame,
                     line_start, m_ls, frame_start, m_fs, locked, m_locked, err, m_err);
        end
    endtask

    task automatic check_all_zero(input string name);
        checks++;
        if ({x, y, line_len, frame_lines, line_start, frame_start, locked, err} !== 50'd0) begin
            errors++;
            $display("FAIL %s: x=%0d y=%0d len=%0d fl=%0d ls=%b fs=%b lk=%b err=%b expected all zero",
                     name, x, y, line_len, frame_lines, line_start, frame_start, locked, err);
        end
    endtask

    // ---------------- stimulus ----------------
    // called at a falling edge; returns at the next falling edge
    task automatic tick(input logic h, input logic v);
        hsync_n = h;
        vsync_n = v;
        @(posedge clk);
        #1;
        model_step(h, v);
        check_cycle();
        if (err === 1'b1) err_pulses++;
        @(negedge clk);
    endtask

    task automatic drive_line(input int per, input logic v);
        for (int c = 0; c < per; c++) tick((c < HW) ? 1'b0 : 1'b1, v);
    endtask

    task automatic drive_frame(input int hper, input int vlines, input int bad_line, input int bad_per);
        for (int l = 0; l < vlines; l++)
            drive_line((l == bad_line) ? bad_per : hper, (l == 0) ? 1'b0 : 1'b1);
    endtask

    task automatic do_reset(input logic h, input logic v);
        rst_n   = 1'b0;
        hsync_n = h;
        vsync_n = v;
        #1;
        check_all_zero("reset state");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        err_pulses = 0;
    endtask

    typedef struct {
        int hper;
        int vlines;
        int frames;
        int exp_len;
        int exp_frame;
        int exp_y;
        bit exp_locked;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int found, pending, ls_cnt, fs_cnt, early, prev_err, hper, vlines, bad;
        rst_n   = 1'b1;
        hsync_n = 1'b1;
        vsync_n = 1'b1;
        model_reset();
        @(negedge clk);

        // ---- scenario table: clean streams, final measurements ----
        vecs[0] = '{800, 4, 5, 800, 4, 3, 1'b1};
        vecs[1] = '{40, 10, 5, 40, 10, 9, 1'b1};
        vecs[2] = '{37, 9, 3, 37, 9, 8, 1'b0};
        vecs[3] = '{64, 5, 4, 64, 5, 4, 1'b1};
        vecs[4] = '{16, 30, 4, 16, 30, 29, 1'b1};
        vecs[5] = '{10, 3, 6, 10, 3, 2, 1'b1};
        vecs[6] = '{50, 7, 2, 50, 7, 6, 1'b0};
        for (int i = 0; i < 7; i++) begin
            do_reset(1'b1, 1'b1);
            for (int f = 0; f < vecs[i].frames; f++) drive_frame(vecs[i].hper, vecs[i].vlines, -1, 0);
            check_val($sformatf("vec%0d line_len", i), int'(line_len), vecs[i].exp_len);
            check_val($sformatf("vec%0d frame_lines", i), int'(frame_lines), vecs[i].exp_frame);
            check_val($sformatf("vec%0d y", i), int'(y), vecs[i].exp_y);
            check_val($sformatf("vec%0d locked", i), int'(locked), int'(vecs[i].exp_locked));
            check_val($sformatf("vec%0d err pulses", i), err_pulses, 0);
        end

        // ---- stretched line while locked, then relock ----
        do_reset(1'b1, 1'b1);
        for (int f = 0; f < 4; f++) drive_frame(40, 8, -1, 0);
        check_val("pre-stretch locked", int'(locked), 1);
        drive_frame(40, 8, 3, 43);
        check_val("stretch err pulses", err_pulses, 1);
        check_val("stretch locked", int'(locked), 0);
        for (int f = 0; f < 3; f++) drive_frame(40, 8, -1, 0);
        check_val("relock after 3 frames", int'(locked), 0);
        drive_frame(40, 8, -1, 0);
        check_val("relock at 4th vsync", int'(locked), 1);

        // ---- one-clock jitter while locked ----
        prev_err = err_pulses;
        drive_frame(40, 8, 2, 41);
        drive_frame(40, 8, 5, 39);
        check_val("jitter err pulses", err_pulses, prev_err);
        check_val("jitter locked", int'(locked), 1);

        // ---- hsync and vsync asserted on the same clock ----
        found   = 0;
        pending = 0;
        for (int c = 0; c < 40; c++) begin
            tick((c < HW) ? 1'b0 : 1'b1, 1'b0);
            if (pending == 1) begin
                check_val("simul x", int'(x), 0);
                check_val("simul y", int'(y), 0);
                check_val("simul frame_lines", int'(frame_lines), 8);
                pending = 0;
            end
            if (line_start === 1'b1 && found == 0) begin
                found = 1;
                pending = 1;
                check_val("simul frame_start", int'(frame_start), 1);
            end
        end
        check_val("simul pulse seen", found, 1);
        for (int l = 1; l < 8; l++) drive_line(40, 1'b1);
        check_val("simul still locked", int'(locked), 1);

        // ---- hsync lost: x saturates ----
        prev_err = err_pulses;
        for (int i = 0; i < 4300; i++) tick(1'b1, 1'b1);
        check_val("sat err pulses", err_pulses, prev_err + 1);
        check_val("sat locked", int'(locked), 0);
        check_val("sat x", int'(x), 4095);

        // ---- one-clock reset pulse while locked ----
        do_reset(1'b1, 1'b1);
        for (int f = 0; f < 4; f++) drive_frame(40, 8, -1, 0);
        check_val("pre-reset locked", int'(locked), 1);
        rst_n = 1'b0;
        #1;
        check_all_zero("async reset");
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        err_pulses = 0;
        for (int f = 0; f < 3; f++) drive_frame(40, 8, -1, 0);
        check_val("post-reset 3 frames locked", int'(locked), 0);
        drive_frame(40, 8, -1, 0);
        check_val("post-reset relock", int'(locked), 1);
        check_val("post-reset err pulses", err_pulses, 0);

        // ---- inputs held low across reset release ----
        do_reset(1'b0, 1'b0);
        ls_cnt = 0;
        fs_cnt = 0;
        early  = 0;
        for (int i = 1; i <= 10; i++) begin
            tick(1'b0, 1'b0);
            if (line_start === 1'b1) begin ls_cnt++; if (i < 3) early++; end
            if (frame_start === 1'b1) fs_cnt++;
        end
        check_val("held-low early pulses", early, 0);
        check_val("held-low line_start count", ls_cnt, 1);
        check_val("held-low frame_start count", fs_cnt, 1);

        // ---- randomised frames with occasional bad lines and pin noise ----
        do_reset(1'b1, 1'b1);
        for (int s = 0; s < 8; s++) begin
            hper   = int'($urandom_range(10, 50));
            vlines = int'($urandom_range(3, 9));
            for (int f = 0; f < 6; f++) begin
                bad = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, vlines - 1)) : -1;
                drive_frame(hper, vlines, bad, hper + int'($urandom_range(0, 6)) - 3);
            end
            for (int i = 0; i < 12; i++)
                tick(($urandom_range(0, 3) == 0) ? 1'b0 : 1'b1, ($urandom_range(0, 3) == 0) ? 1'b0 : 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
